// File: rtl/axi_lite_const_regs.sv
// axi_lite_const_regs
// AXI4-Lite slave register block. Low word indices hold per-instance constant
// words (IDs, version, build); the words above them are byte-strobed R/W
// registers whose contents are exported to fabric together with a one-cycle
// write-notification pulse per register. Decode misses answer with SLVERR.
module axi_lite_const_regs #(
   parameter int                    C_S00_AXI_DATA_WIDTH = 32,
   parameter int                    C_S00_AXI_ADDR_WIDTH = 6,
   parameter int                    NUM_CONST            = 4,
   parameter logic [NUM_CONST*32-1:0] CONST_VALUES       = {32'h0000_0001, 32'h2025_0318,
                                                            32'hCAFE_F00D, 32'hDEADBEEF},
   parameter int                    NUM_RW               = 4,
   parameter logic [31:0]           RW_RESET_VALUE       = 32'h0
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_areset,

   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,

   input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,

   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,

   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,

   output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,

   output logic [NUM_RW*32-1:0]              rw_regs,
   output logic [NUM_RW-1:0]                 rw_wr_pulse
);

   localparam int DW    = C_S00_AXI_DATA_WIDTH;
   localparam int AW    = C_S00_AXI_ADDR_WIDTH;
   localparam int IDX_W = AW - 2;
   localparam int SW    = DW / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;

   // ------------------------------------------------------------------
   // Register file storage (packed so register j sits at [32j+31:32j])
   // ------------------------------------------------------------------
   logic [NUM_RW-1:0][DW-1:0] rw_q;
   logic [NUM_RW-1:0][DW-1:0] rw_d;
   logic [NUM_RW-1:0]         pulse_q;
   logic [NUM_RW-1:0]         pulse_d;

   // ------------------------------------------------------------------
   // Read channel state
   // ------------------------------------------------------------------
   rd_state_e        rd_state_q;
   rd_state_e        rd_state_d;
   logic             arready_q;
   logic             arready_d;
   logic             rvalid_q;
   logic             rvalid_d;
   logic [DW-1:0]    rdata_q;
   logic [DW-1:0]    rdata_d;
   logic [1:0]       rresp_q;
   logic [1:0]       rresp_d;

   logic [IDX_W-1:0] rd_idx;
   logic [DW-1:0]    rd_value;
   logic [1:0]       rd_resp;

   // ------------------------------------------------------------------
   // Write channel state
   // ------------------------------------------------------------------
   logic             aw_held_q;
   logic             aw_held_d;
   logic [IDX_W-1:0] aw_idx_q;
   logic [IDX_W-1:0] aw_idx_d;
   logic             w_held_q;
   logic             w_held_d;
   logic [DW-1:0]    w_data_q;
   logic [DW-1:0]    w_data_d;
   logic [SW-1:0]    w_strb_q;
   logic [SW-1:0]    w_strb_d;
   logic             awready_q;
   logic             awready_d;
   logic             wready_q;
   logic             wready_d;
   logic             bvalid_q;
   logic             bvalid_d;
   logic [1:0]       bresp_q;
   logic [1:0]       bresp_d;

   logic             aw_hs;
   logic             w_hs;
   logic             commit;
   logic [IDX_W-1:0] wr_idx;
   logic [DW-1:0]    wr_data;
   logic [SW-1:0]    wr_strb;

   // Protection bits and the byte offset inside a word carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                            s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   assign rd_idx = s00_axi_araddr[AW-1:2];

   // Decode the read index: constant word, current R/W contents, or a miss.
   always_comb begin
      rd_value = '0;
      rd_resp  = RESP_SLVERR;
      for (int i = 0; i < NUM_CONST; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_value = CONST_VALUES[32*i +: DW];
            rd_resp  = RESP_OKAY;
         end
      end
      for (int j = 0; j < NUM_RW; j++) begin
         if (rd_idx == IDX_W'(NUM_CONST + j)) begin
            rd_value = rw_q[j];
            rd_resp  = RESP_OKAY;
         end
      end
   end

   // Two-state read FSM; data is captured at the AR handshake and held until R completes.
   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (s00_axi_arvalid && arready_q) begin
               rd_state_d = R_DATA;
               arready_d  = 1'b0;
               rvalid_d   = 1'b1;
               rdata_d    = rd_value;
               rresp_d    = rd_resp;
            end
         end
         R_DATA: begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            if (s00_axi_rready) begin
               rd_state_d = R_IDLE;
               arready_d  = 1'b1;
               rvalid_d   = 1'b0;
            end
         end
         default: begin
            rd_state_d = R_IDLE;
            arready_d  = 1'b0;
            rvalid_d   = 1'b0;
         end
      endcase
   end

   // Read channel registers; every read-side AXI output comes straight from a flop.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   // ------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------
   assign aw_hs   = s00_axi_awvalid & awready_q;
   assign w_hs    = s00_axi_wvalid & wready_q;
   assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
   assign wr_idx  = aw_held_q ? aw_idx_q : s00_axi_awaddr[AW-1:2];
   assign wr_data = w_held_q ? w_data_q : s00_axi_wdata;
   assign wr_strb = w_held_q ? w_strb_q : s00_axi_wstrb;

   // Latch AW and W independently, commit once both are present, then hold the response.
   always_comb begin
      aw_held_d = aw_held_q | aw_hs;
      aw_idx_d  = aw_hs ? s00_axi_awaddr[AW-1:2] : aw_idx_q;
      w_held_d  = w_held_q | w_hs;
      w_data_d  = w_hs ? s00_axi_wdata : w_data_q;
      w_strb_d  = w_hs ? s00_axi_wstrb : w_strb_q;
      bvalid_d  = bvalid_q & ~s00_axi_bready;
      bresp_d   = bresp_q;
      pulse_d   = '0;
      rw_d      = rw_q;
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_SLVERR;
         for (int j = 0; j < NUM_RW; j++) begin
            if (wr_idx == IDX_W'(NUM_CONST + j)) begin
               bresp_d    = RESP_OKAY;
               pulse_d[j] = 1'b1;
               for (int k = 0; k < SW; k++) begin
                  if (wr_strb[k]) begin
                     rw_d[j][8*k +: 8] = wr_data[8*k +: 8];
                  end
               end
            end
         end
      end
      awready_d = ~aw_held_d & ~bvalid_d;
      wready_d  = ~w_held_d & ~bvalid_d;
   end

   // Write channel registers, register file and notification pulses.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         pulse_q   <= '0;
         rw_q      <= {NUM_RW{RW_RESET_VALUE}};
      end else begin
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         pulse_q   <= pulse_d;
         rw_q      <= rw_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = rresp_q;
   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = wready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = bresp_q;
   assign rw_regs         = rw_q;
   assign rw_wr_pulse     = pulse_q;

endmodule

// File: tb/tb_axi_lite_const_regs.sv
// Directed testbench for axi_lite_const_regs with the default parameter set.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi_lite_const_regs;

   logic        clk = 1'b0;
   logic        areset;
   logic [5:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [127:0] rw_regs;
   logic [3:0]  rw_wr_pulse;

   int vectors     = 0;
   int miscompares = 0;
   int pulse_cycles = 0;

   axi_lite_const_regs dut (
      .s00_axi_aclk    (clk),
      .s00_axi_areset  (areset),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready),
      .rw_regs         (rw_regs),
      .rw_wr_pulse     (rw_wr_pulse)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Count every cycle in which any write-notification pulse was high
   always @(posedge clk) begin
      if (|rw_wr_pulse) pulse_cycles++;
   end

   // Hard stop in case a scenario wedges outside the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Single read transaction: returns data, response and cycles from AR handshake to rvalid
   task automatic do_read(input int idx, output logic [31:0] data, output logic [1:0] resp,
                          output int lat);
      int n;
      araddr  = 6'(idx * 4);
      arvalid = 1'b1;
      n = 0;
      while (arready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         vectors++; miscompares++;
         $display("[TB] FAIL rd_arready_timeout: got %0b want 1", arready);
      end
      @(negedge clk);
      arvalid = 1'b0;
      lat = 0;
      while (rvalid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) begin
         vectors++; miscompares++;
         $display("[TB] FAIL rd_rvalid_timeout: got %0b want 1", rvalid);
      end
      data   = rdata;
      resp   = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   // Single write transaction with AW and W offered together; returns bresp
   task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
      int   n;
      logic aw_go;
      logic w_go;
      awaddr  = 6'(idx * 4);
      wdata   = data;
      wstrb   = strb;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 20) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(negedge clk);
         if (aw_go) awvalid = 1'b0;
         if (w_go)  wvalid  = 1'b0;
         n++;
      end
      if (n >= 20) begin
         vectors++; miscompares++;
         $display("[TB] FAIL wr_ready_timeout: awready=%0b wready=%0b", awready, wready);
         awvalid = 1'b0;
         wvalid  = 1'b0;
      end
      n = 0;
      while (bvalid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         vectors++; miscompares++;
         $display("[TB] FAIL wr_bvalid_timeout: got %0b want 1", bvalid);
      end
      resp   = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   // Reset values while held, then readies rising one edge after release
   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (arready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_arready: got %0b want 0", arready); end
      vectors++; if (awready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_awready: got %0b want 0", awready); end
      vectors++; if (wready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wready: got %0b want 0", wready); end
      vectors++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valids: got rvalid=%0b bvalid=%0b want 0 0", rvalid, bvalid); end
      vectors++; if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_data_resp: got rdata=%h rresp=%b bresp=%b want 0", rdata, rresp, bresp); end
      vectors++; if (rw_regs !== 128'h0) begin miscompares++; $display("[TB] FAIL rst_rw_regs: got %h want 0", rw_regs); end
      vectors++; if (rw_wr_pulse !== 4'b0) begin miscompares++; $display("[TB] FAIL rst_pulse: got %b want 0000", rw_wr_pulse); end
      areset = 1'b0;
      @(negedge clk);
      vectors++; if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_readies: got ar=%0b aw=%0b w=%0b want 1 1 1", arready, awready, wready); end
   endtask

   // Constant words at indices 0..3
   task automatic test_const_reads();
      logic [31:0] exp_const [4];
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      exp_const[0] = 32'hDEADBEEF;
      exp_const[1] = 32'hCAFEF00D;
      exp_const[2] = 32'h20250318;
      exp_const[3] = 32'h00000001;
      for (int i = 0; i < 4; i++) begin
         do_read(i, d, r, lat);
         vectors++; if (d !== exp_const[i]) begin miscompares++; $display("[TB] FAIL const_rdata[%0d]: got %h want %h", i, d, exp_const[i]); end
         vectors++; if (r !== 2'b00) begin miscompares++; $display("[TB] FAIL const_rresp[%0d]: got %b want 00", i, r); end
         vectors++; if (lat !== 0) begin miscompares++; $display("[TB] FAIL const_latency[%0d]: got %0d extra cycles want 0", i, lat); end
      end
   endtask

   // Byte-strobed write to index 4 with pulse timing
   task automatic test_strobe_write();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      awaddr = 6'd16; wdata = 32'h12345678; wstrb = 4'b0101;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      vectors++; if (bvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL strb_bvalid: got %0b want 1", bvalid); end
      vectors++; if (bresp !== 2'b00) begin miscompares++; $display("[TB] FAIL strb_bresp: got %b want 00", bresp); end
      vectors++; if (rw_wr_pulse !== 4'b0001) begin miscompares++; $display("[TB] FAIL strb_pulse_high: got %b want 0001", rw_wr_pulse); end
      vectors++; if (rw_regs[31:0] !== 32'h00340078) begin miscompares++; $display("[TB] FAIL strb_rw_regs0: got %h want 00340078", rw_regs[31:0]); end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      vectors++; if (rw_wr_pulse !== 4'b0000) begin miscompares++; $display("[TB] FAIL strb_pulse_low: got %b want 0000", rw_wr_pulse); end
      vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL strb_bvalid_clear: got %0b want 0", bvalid); end
      do_read(4, d, r, lat);
      vectors++; if (d !== 32'h00340078 || r !== 2'b00) begin miscompares++; $display("[TB] FAIL strb_readback: got %h/%b want 00340078/00", d, r); end
   endtask

   // W ahead of AW, then AW ahead of W; each commits once both are held
   task automatic test_write_order();
      int base;
      base = pulse_cycles;
      wdata = 32'hAAAA5555; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL wfirst_wait[%0d]: got wready=%0b awready=%0b bvalid=%0b want 0 1 0", i, wready, awready, bvalid); end
         @(negedge clk);
      end
      awaddr = 6'd20; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      vectors++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin miscompares++; $display("[TB] FAIL wfirst_b: got bvalid=%0b bresp=%b want 1 00", bvalid, bresp); end
      vectors++; if (rw_regs[63:32] !== 32'hAAAA5555) begin miscompares++; $display("[TB] FAIL wfirst_reg: got %h want AAAA5555", rw_regs[63:32]); end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      @(negedge clk);
      vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL wfirst_single_b: got %0b want 0", bvalid); end

      awaddr = 6'd24; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL awfirst_wait[%0d]: got awready=%0b wready=%0b bvalid=%0b want 0 1 0", i, awready, wready, bvalid); end
         vectors++; if (rw_regs[95:64] !== 32'h0) begin miscompares++; $display("[TB] FAIL awfirst_early: got %h want 00000000", rw_regs[95:64]); end
         @(negedge clk);
      end
      wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      vectors++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin miscompares++; $display("[TB] FAIL awfirst_b: got bvalid=%0b bresp=%b want 1 00", bvalid, bresp); end
      vectors++; if (rw_regs[95:64] !== 32'h0BADF00D) begin miscompares++; $display("[TB] FAIL awfirst_reg: got %h want 0BADF00D", rw_regs[95:64]); end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      @(negedge clk);
      vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL awfirst_single_b: got %0b want 0", bvalid); end
      vectors++; if (pulse_cycles - base !== 2) begin miscompares++; $display("[TB] FAIL order_pulses: got %0d want 2", pulse_cycles - base); end
   endtask

   // Writes to a constant and an out-of-range index; reads around the decode boundary
   task automatic test_slverr();
      logic [127:0] exp_regs;
      logic [31:0]  d;
      logic [1:0]   r;
      int           lat;
      int           base;
      exp_regs = {32'h0, 32'h0BADF00D, 32'hAAAA5555, 32'h00340078};
      base = pulse_cycles;
      do_write(1, 32'hFFFFFFFF, 4'hF, r);
      vectors++; if (r !== 2'b10) begin miscompares++; $display("[TB] FAIL err_wr_const_bresp: got %b want 10", r); end
      do_write(12, 32'hFFFFFFFF, 4'hF, r);
      vectors++; if (r !== 2'b10) begin miscompares++; $display("[TB] FAIL err_wr_invalid_bresp: got %b want 10", r); end
      vectors++; if (rw_regs !== exp_regs) begin miscompares++; $display("[TB] FAIL err_regs_unchanged: got %h want %h", rw_regs, exp_regs); end
      vectors++; if (pulse_cycles - base !== 0) begin miscompares++; $display("[TB] FAIL err_no_pulse: got %0d want 0", pulse_cycles - base); end
      do_read(1, d, r, lat);
      vectors++; if (d !== 32'hCAFEF00D || r !== 2'b00) begin miscompares++; $display("[TB] FAIL err_const_intact: got %h/%b want CAFEF00D/00", d, r); end
      do_read(12, d, r, lat);
      vectors++; if (d !== 32'h0 || r !== 2'b10) begin miscompares++; $display("[TB] FAIL err_rd_idx12: got %h/%b want 00000000/10", d, r); end
      do_read(8, d, r, lat);
      vectors++; if (d !== 32'h0 || r !== 2'b10) begin miscompares++; $display("[TB] FAIL err_rd_idx8: got %h/%b want 00000000/10", d, r); end
      do_read(7, d, r, lat);
      vectors++; if (d !== 32'h0 || r !== 2'b00) begin miscompares++; $display("[TB] FAIL err_rd_idx7: got %h/%b want 00000000/00", d, r); end
   endtask

   // Held-off rready and bready keep responses stable and block new requests
   task automatic test_stall();
      int base;
      araddr = 6'd16; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vectors++; if (rvalid !== 1'b1 || rdata !== 32'h00340078 || rresp !== 2'b00 || arready !== 1'b0) begin miscompares++; $display("[TB] FAIL rstall[%0d]: got rvalid=%0b rdata=%h rresp=%b arready=%0b want 1 00340078 00 0", i, rvalid, rdata, rresp, arready); end
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      vectors++; if (rvalid !== 1'b0 || arready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstall_release: got rvalid=%0b arready=%0b want 0 1", rvalid, arready); end

      base = pulse_cycles;
      awaddr = 6'd28; wdata = 32'h11223344; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin
            awaddr = 6'd16; wdata = 32'h0; wstrb = 4'hF;
            awvalid = 1'b1; wvalid = 1'b1;
         end
         vectors++; if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin miscompares++; $display("[TB] FAIL bstall[%0d]: got bvalid=%0b bresp=%b awready=%0b wready=%0b want 1 00 0 0", i, bvalid, bresp, awready, wready); end
         vectors++; if (rw_regs[127:96] !== 32'h11223344 || rw_regs[31:0] !== 32'h00340078) begin miscompares++; $display("[TB] FAIL bstall_regs[%0d]: got r3=%h r0=%h want 11223344 00340078", i, rw_regs[127:96], rw_regs[31:0]); end
         @(negedge clk);
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      vectors++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin miscompares++; $display("[TB] FAIL bstall_release: got bvalid=%0b awready=%0b wready=%0b want 0 1 1", bvalid, awready, wready); end
      vectors++; if (pulse_cycles - base !== 1) begin miscompares++; $display("[TB] FAIL bstall_pulses: got %0d want 1", pulse_cycles - base); end
      vectors++; if (rw_regs[31:0] !== 32'h00340078) begin miscompares++; $display("[TB] FAIL bstall_reg0: got %h want 00340078", rw_regs[31:0]); end
   endtask

   // Read and write to index 5 on the same edge, then reset over a pending response
   task automatic test_concurrent_and_reset();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      araddr = 6'd20; arvalid = 1'b1;
      awaddr = 6'd20; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      vectors++; if (rvalid !== 1'b1 || rdata !== 32'hAAAA5555 || rresp !== 2'b00) begin miscompares++; $display("[TB] FAIL conc_old_data: got rvalid=%0b rdata=%h rresp=%b want 1 AAAA5555 00", rvalid, rdata, rresp); end
      vectors++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin miscompares++; $display("[TB] FAIL conc_b: got bvalid=%0b bresp=%b want 1 00", bvalid, bresp); end
      vectors++; if (rw_regs[63:32] !== 32'h5A5A5A5A || rw_wr_pulse !== 4'b0010) begin miscompares++; $display("[TB] FAIL conc_reg_pulse: got %h/%b want 5A5A5A5A/0010", rw_regs[63:32], rw_wr_pulse); end
      rready = 1'b1; bready = 1'b1;
      @(negedge clk);
      rready = 1'b0; bready = 1'b0;
      do_read(5, d, r, lat);
      vectors++; if (d !== 32'h5A5A5A5A || r !== 2'b00) begin miscompares++; $display("[TB] FAIL conc_new_data: got %h/%b want 5A5A5A5A/00", d, r); end

      awaddr = 6'd16; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      araddr = 6'd0; arvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      vectors++; if (bvalid !== 1'b1 || rvalid !== 1'b1 || rw_regs[31:0] !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL prereset_state: got bvalid=%0b rvalid=%0b r0=%h want 1 1 FFFFFFFF", bvalid, rvalid, rw_regs[31:0]); end
      areset = 1'b1;
      @(negedge clk);
      vectors++; if (bvalid !== 1'b0 || rvalid !== 1'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_outputs: got bvalid=%0b rvalid=%0b bresp=%b rresp=%b rdata=%h want all 0", bvalid, rvalid, bresp, rresp, rdata); end
      vectors++; if (arready !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_readies: got ar=%0b aw=%0b w=%0b want 0 0 0", arready, awready, wready); end
      vectors++; if (rw_regs !== 128'h0 || rw_wr_pulse !== 4'b0) begin miscompares++; $display("[TB] FAIL midrst_regs: got %h/%b want 0/0000", rw_regs, rw_wr_pulse); end
      areset = 1'b0;
      @(negedge clk);
      vectors++; if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL postrst_readies: got ar=%0b aw=%0b w=%0b bvalid=%0b want 1 1 1 0", arready, awready, wready, bvalid); end
      do_read(4, d, r, lat);
      vectors++; if (d !== 32'h0 || r !== 2'b00) begin miscompares++; $display("[TB] FAIL postrst_idx4: got %h/%b want 00000000/00", d, r); end
   endtask

   initial begin
      areset  = 1'b1;
      awaddr  = '0; awprot = 3'b000; awvalid = 1'b0;
      wdata   = '0; wstrb  = 4'h0;   wvalid  = 1'b0;
      bready  = 1'b0;
      araddr  = '0; arprot = 3'b000; arvalid = 1'b0;
      rready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_const_reads();
      test_strobe_write();
      test_write_order();
      test_slverr();
      test_stall();
      test_concurrent_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_lite_const_regs.md
# axi_lite_const_regs

- AXI4-Lite slave register block with a parametrised register file.
- Lower word indices are read-only constant registers: IDs, version and build words, fixed per instance.
- Upper word indices are byte-strobed read/write registers. Their contents are exported to fabric.
- Sits on the processor AXI interconnect as the generalised successor of the single-constant read-only slave, adding full write-channel support and SLVERR decode errors.

## Interface

- C_S00_AXI_DATA_WIDTH, 32 — data width; only 32 is supported.
- C_S00_AXI_ADDR_WIDTH, 6 — byte address width; word index = addr[ADDR_WIDTH-1:2].
- NUM_CONST, 4 — number of constant registers (1..8), at word indices 0..NUM_CONST-1.
- CONST_VALUES, {32'h0000_0001, 32'h2025_0318, 32'hCAFE_F00D, 32'hDEADBEEF} — packed NUM_CONST*32 bits; word i = bits [32i+31:32i] (index 0 = DEADBEEF).
- NUM_RW, 4 — number of R/W registers (1..8), at word indices NUM_CONST..NUM_CONST+NUM_RW-1.
- RW_RESET_VALUE, 32'h0 — reset value of every R/W register.
- NUM_CONST+NUM_RW must not exceed 2^(ADDR_WIDTH-2).

Ports:
- s00_axi_aclk in 1 — clock.
- s00_axi_areset in 1 — synchronous reset, active-high.
- s00_axi_awaddr in ADDR_WIDTH; s00_axi_awprot in 3 (ignored); s00_axi_awvalid in 1; s00_axi_awready out 1.
- s00_axi_wdata in 32; s00_axi_wstrb in 4; s00_axi_wvalid in 1; s00_axi_wready out 1.
- s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1.
- s00_axi_araddr in ADDR_WIDTH; s00_axi_arprot in 3 (ignored); s00_axi_arvalid in 1; s00_axi_arready out 1.
- s00_axi_rdata out 32; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1.
- rw_regs out NUM_RW*32 — R/W register contents; register j at bits [32j+31:32j].
- rw_wr_pulse out NUM_RW — one-cycle pulse per R/W register, on the cycle after a committed write to it.

## Operation

Address decode:
- Address bits [1:0] are ignored.
- An index is valid if it is below NUM_CONST+NUM_RW.

Read channel FSM, states R_IDLE and R_DATA:
- R_IDLE: arready=1. On arvalid&arready, capture the decode and load rdata/rresp at that same edge, then go to R_DATA.
- R_DATA: arready=0, rvalid=1. rdata and rresp are held stable until rvalid&rready, then return to R_IDLE.
- Read of a constant index: rdata = CONST_VALUES word, OKAY.
- Read of an R/W index: rdata = register value before any write committing on the same edge (read-before-write), OKAY.
- Read of an invalid index: rdata = 0, rresp = SLVERR (2'b10).

Write channel:
- AW and W are accepted independently, in either order.
- awready=1 while no address is latched and bvalid=0. wready=1 while no data is latched and bvalid=0.
- Commit occurs at the edge where both address and data are held, counting a handshake on that same edge.
- On commit, for an R/W index: update each byte k where wstrb[k]=1; set bresp OKAY; set rw_wr_pulse[j] for the following cycle. A pulse is issued even if wstrb=0.
- On commit, for a constant index or an invalid index: no state change, no pulse, bresp = SLVERR.
- bvalid=1 from the cycle after commit until bvalid&bready. Both latches clear on the commit edge.
- While bvalid=1, awready=wready=0.
- The read and write channels are fully independent and may be active concurrently.

Reset (synchronous, active-high):
- All valids, readies and resp fields = 0; rdata = 0; rw_wr_pulse = 0.
- R/W registers = RW_RESET_VALUE; write latches cleared; read FSM in R_IDLE.
- arready, awready and wready rise on the first edge after reset deasserts.
- Reset asserted mid-transaction aborts it. No write commits unless its commit edge precedes the reset edge.

## Timing

Read:
- AR handshake at edge k; rvalid visible after edge k (1-cycle latency).
- R handshake at edge m; arready=1 after edge m.
- Peak throughput: one read per 2 cycles.

Write:
- AW and W in the same cycle, handshake at edge k: register updated and bvalid=1 after edge k.
- rw_wr_pulse high for the single cycle after edge k, i.e. the first cycle bvalid is high.

Other:
- bready held low stalls further writes indefinitely. Registers stay stable and no extra pulses are issued.
- No combinational path from any input to any output. All AXI outputs are registered.

## Test plan

1. Reset, then read indices 0..3 → rdata DEADBEEF, CAFEF00D, 20250318, 00000001; rresp OKAY; rvalid one cycle after each AR handshake.
2. Write 0x12345678 to index 4 with wstrb=4'b0101, after reset value 0 → readback 0x00340078; rw_regs[31:0] = 0x00340078; rw_wr_pulse[0] high for exactly 1 cycle.
3. W presented 3 cycles before AW; then the reverse order → each commits only once both are held; exactly one bvalid each, OKAY.
4. Write to index 1 and to index 12 → bresp SLVERR, no register change, no pulse. Read of index 12 → rdata 0, rresp SLVERR.
5. rready held low 5 cycles, and bready held low 5 cycles → rdata/rvalid and bvalid stable; arready, awready and wready stay 0 until the respective handshake.
6. Concurrent read and write to index 5 with the AR and W/AW handshakes on the same edge → rdata returns the old value; a subsequent read returns the new value. Assert reset during a pending bvalid → all valids 0 next cycle, registers return to RW_RESET_VALUE.
